rvv_insn_sequencer: RTL
=======================

// Module: rvv_insn_sequencer
//
// PURPOSE
//   Synthesizable instruction sequencer that replaces the hard-coded per-cycle instruction
//   feed into rvv_proc_main. It holds a loadable instruction store and issues a programmed
//   number of instructions. Issue uses a valid/ready handshake.
//   It can insert a programmable number of NOP beats after every instruction, to cover
//   hazards until dependency checking exists. It can replay the program in a loop.
//
// PARAMETERS
//   INSN_WIDTH  32            instruction width in bits
//   MEM_DEPTH   128           instruction store depth in entries (>=2)
//   GAP_W       4             width of the NOP-gap count
//   NOP_INSN    32'h00000000  encoding issued as a NOP
//   ADDR_W      $clog2(MEM_DEPTH)  localparam, derived
//
// PORTS
//   clk          in   1           clock
//   rst          in   1           reset, asynchronous, active-low
//   ld_en        in   1           write ld_data into the store at ld_addr; ignored while busy
//   ld_addr      in   ADDR_W      store write address
//   ld_data      in   INSN_WIDTH  store write data
//   start        in   1           begin a run; sampled only in IDLE
//   stop         in   1           abort the current run
//   insn_count   in   ADDR_W+1    number of instructions in a run; latched at start
//   loop_mode    in   1           1 = replay from entry 0 after the last entry; latched at start
//   nop_gap      in   GAP_W       NOP beats after each instruction; latched at start
//   insn_ready   in   1           processor accepts insn_out this cycle
//   insn_out     out  INSN_WIDTH  issued instruction or NOP_INSN
//   insn_valid   out  1           insn_out is valid
//   pc           out  ADDR_W      store index of the current or last-issued instruction
//   busy         out  1           a run is in progress
//   done         out  1           one-cycle pulse when a non-loop run completes
//
// BEHAVIOUR
//   - Reset values: insn_out=NOP_INSN, insn_valid=0, pc=0, busy=0, done=0, state=IDLE.
//     Store contents are not reset. Reset asserted mid-run aborts immediately, with no done pulse.
//   - Store: synchronous write, asynchronous read. A write on cycle N is readable on cycle N+1.
//   - A beat is any cycle with insn_valid & insn_ready. insn_out and insn_valid are registered.
//     While insn_valid=1 & insn_ready=0, insn_out and pc hold stable.
//   - States: IDLE, ISSUE, GAP, FIN.
//   - IDLE, start=1, count!=0:
//       latch cnt=min(insn_count,MEM_DEPTH), gap, loop.
//       Next cycle: ISSUE with insn_out=mem[0], insn_valid=1, pc=0, busy=1.
//   - IDLE, start=1, count==0: go to FIN. No beats are issued.
//   - ISSUE, beat:
//       gap!=0 -> GAP, gcnt=gap, insn_out=NOP_INSN.
//       gap==0 and pc<cnt-1 -> pc+1, insn_out=mem[pc+1].
//       gap==0 and pc==cnt-1 -> loop ? pc=0 with insn_out=mem[0] : FIN.
//   - GAP: every NOP is a full beat, subject to insn_ready. Each beat decrements gcnt.
//     On the beat where gcnt==1, advance exactly as the ISSUE/gap==0 row does
//     (next instruction, wrap to 0, or FIN).
//   - FIN: insn_valid=0, insn_out=NOP_INSN, busy=0, done=1 for exactly one cycle, then IDLE.
//   - Loop runs never assert done; only stop or reset ends them.
//   - stop: in any non-IDLE state, the next edge returns to IDLE.
//     insn_valid=0, busy=0, done stays 0, pc holds. A beat in the same cycle still counts as
//     consumed. stop wins over start in the same cycle.
//   - start while busy is ignored. ld_en while busy is ignored.
//   - pc wraps with no other side effects. Store reads never index at or beyond cnt.
//
// STRUCTURE
//   - Package rvv_seq_pkg: seq_state_e enum {IDLE,ISSUE,GAP,FIN}; default NOP_INSN constant.
//     INSN_WIDTH default shared with rvv_proc_main.
//   - Sub-module rvv_insn_mem: MEM_DEPTH x INSN_WIDTH store, one synchronous write port,
//     one asynchronous read port.
//   - Top: FSM, pc and gcnt counters, latched run configuration, output register.
//
// TESTING
//   1. Load 0x00110257,0x000182D7,0x00428357. count=3, gap=0, ready=1, start.
//      -> 3 consecutive beats in that order on cycles 1..3, done on cycle 4, busy=0 on cycle 4.
//   2. Same program, gap=2. -> beats: I0,NOP,NOP,I1,NOP,NOP,I2,NOP,NOP (9 beats), then done.
//   3. Same program, gap=0, ready low for 3 cycles after the first valid cycle.
//      -> insn_out stays 0x00110257 and pc=0 during the stall. Total 3 beats, then done.
//   4. loop=1, count=2, gap=0. -> beats I0,I1,I0,I1,... with pc 0,1,0,1 and done never asserted.
//      stop while I1 is pending -> next cycle insn_valid=0, busy=0, done=0.
//   5. count=0 with start -> done pulses one cycle, zero beats.
//      count=MEM_DEPTH+5 -> exactly MEM_DEPTH beats.
//   6. rst low mid-run -> all outputs at reset values within that cycle.
//      ld_en while busy -> store unchanged. start plus stop in the same IDLE cycle -> stays IDLE.

Source files
------------

// File: rtl/rvv_seq_pkg.sv
// rvv_seq_pkg: shared types and defaults for the rvv instruction sequencer
package rvv_seq_pkg;
    localparam int INSN_WIDTH_DEF = 32;
    localparam logic [INSN_WIDTH_DEF-1:0] NOP_INSN_DEF = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} seq_state_e;
endpackage

// File: rtl/rvv_insn_mem.sv
// rvv_insn_mem: instruction store with one synchronous write port and one asynchronous read port
module rvv_insn_mem
    import rvv_seq_pkg::*;
#(
    parameter int INSN_WIDTH = INSN_WIDTH_DEF,
    parameter int MEM_DEPTH = 128,
    localparam int ADDR_W = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [INSN_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [INSN_WIDTH-1:0] rdata
);
    logic [INSN_WIDTH-1:0] mem [MEM_DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/rvv_insn_sequencer.sv
// rvv_insn_sequencer: issues a loaded instruction program over valid/ready with optional NOP gaps and looping
module rvv_insn_sequencer
    import rvv_seq_pkg::*;
#(
    parameter int INSN_WIDTH = INSN_WIDTH_DEF,
    parameter int MEM_DEPTH = 128,
    parameter int GAP_W = 4,
    parameter logic [INSN_WIDTH-1:0] NOP_INSN = NOP_INSN_DEF,
    localparam int ADDR_W = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_en,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [INSN_WIDTH-1:0] ld_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_W:0]       insn_count,
    input  logic                  loop_mode,
    input  logic [GAP_W-1:0]      nop_gap,
    input  logic                  insn_ready,
    output logic [INSN_WIDTH-1:0] insn_out,
    output logic                  insn_valid,
    output logic [ADDR_W-1:0]     pc,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);
    seq_state_e state, state_n;
    logic [ADDR_W-1:0] pc_n, nxt, raddr;
    logic [ADDR_W:0] cnt, cnt_n;
    logic [GAP_W-1:0] gap, gap_n, gcnt, gcnt_n;
    logic loop, loop_n, valid_n, busy_n, done_n, beat, last, adv;
    logic [INSN_WIDTH-1:0] out_n, rdata;
    rvv_insn_mem #(.INSN_WIDTH(INSN_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_mem (
        .clk(clk), .we(ld_en && !busy), .waddr(ld_addr), .wdata(ld_data),
        .raddr(raddr), .rdata(rdata)
    );
    assign beat  = insn_valid && insn_ready;
    assign last  = {1'b0, pc} == cnt - (ADDR_W+1)'(1);
    assign nxt   = last ? '0 : pc + ADDR_W'(1);
    assign raddr = (state == IDLE) ? '0 : nxt;
    always_comb begin
        state_n = state;
        pc_n    = pc;
        gcnt_n  = gcnt;
        cnt_n   = cnt;
        gap_n   = gap;
        loop_n  = loop;
        out_n   = insn_out;
        valid_n = insn_valid;
        busy_n  = busy;
        done_n  = 1'b0;
        adv     = 1'b0;
        case (state)
            IDLE: if (start && !stop) begin
                if (insn_count != '0) begin
                    state_n = ISSUE;
                    cnt_n   = (insn_count > DEPTH_C) ? DEPTH_C : insn_count;
                    gap_n   = nop_gap;
                    loop_n  = loop_mode;
                    pc_n    = '0;
                    out_n   = rdata;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end else begin
                    state_n = FIN;
                    done_n  = 1'b1;
                end
            end
            ISSUE: if (beat) begin
                if (gap != '0) begin
                    state_n = GAP;
                    gcnt_n  = gap;
                    out_n   = NOP_INSN;
                end else adv = 1'b1;
            end
            GAP: if (beat) begin
                gcnt_n = gcnt - GAP_W'(1);
                adv    = gcnt == GAP_W'(1);
            end
            default: state_n = IDLE;
        endcase
        if (adv) begin
            if (!last || loop) begin
                state_n = ISSUE;
                pc_n    = nxt;
                out_n   = rdata;
            end else begin
                state_n = FIN;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                out_n   = NOP_INSN;
            end
        end
        if (stop && state != IDLE) begin
            state_n = IDLE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            out_n   = NOP_INSN;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= '0;
            gcnt       <= '0;
            cnt        <= '0;
            gap        <= '0;
            loop       <= 1'b0;
            insn_out   <= NOP_INSN;
            insn_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            gcnt       <= gcnt_n;
            cnt        <= cnt_n;
            gap        <= gap_n;
            loop       <= loop_n;
            insn_out   <= out_n;
            insn_valid <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end
endmodule
